// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates one-cycle effect requests by fixed
// priority onto the single shared tone-store/I2S player, with preemption,
// an inter-effect silence gap, a play timeout and a global mute.
//
// Ports:
//   MCLK          system clock
//   nReset        asynchronous active-low reset
//   req_i         one-cycle request pulses, bit i = effect i (N_REQ-1 highest)
//   mute_i        level; forces silence, flushes and blocks pending requests
//   play_done_i   one-cycle pulse from player: repeat count exhausted
//   snd_id_o      tone select for the current effect
//   snd_rep_o     repeat count for the current effect
//   snd_start_o   one-cycle strobe restarting the player counters
//   onOff_o       enable to the I2S transmitter
//   busy_o        high whenever the scheduler is not idle
//   pending_o     latched requests not yet served
module sfx_scheduler #(
  parameter int unsigned            N_REQ      = 4,
  parameter int unsigned            ID_W       = 2,
  parameter int unsigned            REP_W      = 8,
  parameter logic [N_REQ*REP_W-1:0] REP_TABLE  = {8'd4, 8'd2, 8'd1, 8'd3},
  parameter logic [15:0]            GAP_CYCLES = 16'd1000,
  parameter logic [23:0]            TIMEOUT    = 24'd5000000
) (
  input  logic             MCLK,
  input  logic             nReset,
  input  logic [N_REQ-1:0] req_i,
  input  logic             mute_i,
  input  logic             play_done_i,
  output logic [ID_W-1:0]  snd_id_o,
  output logic [REP_W-1:0] snd_rep_o,
  output logic             snd_start_o,
  output logic             onOff_o,
  output logic             busy_o,
  output logic [N_REQ-1:0] pending_o
);

  typedef enum logic [2:0] {IDLE, LOAD, START, PLAY, STOP, GAP} state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   pending_q, pending_d, clr_c;
  logic [ID_W-1:0]    snd_id_q, pick_c;
  logic [REP_W-1:0]   snd_rep_q, pick_rep_c;
  logic               snd_start_q, onoff_q, busy_q;
  logic               any_c, preempt_c, sel_c;
  logic [15:0]        gap_q;
  logic [23:0]        tmo_q;

  // Priority pick (highest set index) and preemption test against the current effect
  always_comb begin
    pick_c     = '0;
    pick_rep_c = '0;
    preempt_c  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_q[i]) begin
        pick_c     = ID_W'(i);
        pick_rep_c = REP_TABLE[i*REP_W +: REP_W];
        if (i > int'(snd_id_q)) preempt_c = 1'b1;
      end
    end
  end

  // Request latch: a new pulse beats the selection clear on the same bit
  always_comb begin
    any_c     = |pending_q;
    sel_c     = !mute_i && any_c && (state_q == IDLE || state_q == STOP);
    clr_c     = sel_c ? (N_REQ'(1) << pick_c) : '0;
    pending_d = mute_i ? '0 : ((pending_q & ~clr_c) | req_i);
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      snd_id_q    <= '0;
      snd_rep_q   <= '0;
      snd_start_q <= 1'b0;
      onoff_q     <= 1'b0;
      busy_q      <= 1'b0;
      gap_q       <= '0;
      tmo_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      snd_start_q <= 1'b0;
      if (mute_i) begin
        state_q <= IDLE;
        onoff_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (any_c) begin
              snd_id_q  <= pick_c;
              snd_rep_q <= pick_rep_c;
              state_q   <= LOAD;
              busy_q    <= 1'b1;
            end
          end
          LOAD: begin
            state_q     <= START;
            snd_start_q <= 1'b1;
            onoff_q     <= 1'b1;
          end
          START: begin
            state_q <= PLAY;
            tmo_q   <= '0;
          end
          PLAY: begin
            tmo_q <= tmo_q + 24'd1;
            // Completion outranks preemption; the preempting request stays latched
            if (play_done_i) begin
              state_q <= GAP;
              onoff_q <= 1'b0;
              gap_q   <= '0;
            end else if (preempt_c) begin
              state_q <= STOP;
              onoff_q <= 1'b0;
            end else if (tmo_q == TIMEOUT - 24'd1) begin
              state_q <= GAP;
              onoff_q <= 1'b0;
              gap_q   <= '0;
            end
          end
          STOP: begin
            // Preemption skips the gap and loads the winner directly
            if (any_c) begin
              snd_id_q  <= pick_c;
              snd_rep_q <= pick_rep_c;
              state_q   <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          GAP: begin
            gap_q <= gap_q + 16'd1;
            if (gap_q == GAP_CYCLES - 16'd1) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            onoff_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign snd_id_o    = snd_id_q;
  assign snd_rep_o   = snd_rep_q;
  assign snd_start_o = snd_start_q;
  assign onOff_o     = onoff_q;
  assign busy_o      = busy_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios plus random traffic, every
// cycle compared against a phase/countdown reference model.
module tb_sfx_scheduler;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned REP_W = 8;
  localparam logic [15:0] GAP   = 16'd40;
  localparam logic [23:0] TMO   = 24'd300;
  localparam int          GAP_N = 40;
  localparam int          TMO_N = 300;

  logic             MCLK = 1'b0;
  logic             nReset = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             mute = 1'b0;
  logic             done = 1'b0;
  logic [ID_W-1:0]  snd_id_o;
  logic [REP_W-1:0] snd_rep_o;
  logic             snd_start_o, onOff_o, busy_o;
  logic [N_REQ-1:0] pending_o;

  int n_checks = 0;
  int n_errors = 0;

  sfx_scheduler #(
    .N_REQ(N_REQ), .ID_W(ID_W), .REP_W(REP_W),
    .REP_TABLE({8'd4, 8'd2, 8'd1, 8'd3}),
    .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .MCLK(MCLK), .nReset(nReset), .req_i(req), .mute_i(mute),
    .play_done_i(done), .snd_id_o(snd_id_o), .snd_rep_o(snd_rep_o),
    .snd_start_o(snd_start_o), .onOff_o(onOff_o), .busy_o(busy_o),
    .pending_o(pending_o)
  );

  always #5 MCLK = ~MCLK;

  // Reference model: phase plus elapsed/remaining counts
  typedef enum {P_IDLE, P_LOAD, P_START, P_PLAY, P_STOP, P_GAP} phase_t;
  phase_t     m_ph = P_IDLE;
  logic [3:0] m_pend = '0;
  int         m_id = 0, m_rep = 0, m_age = 0, m_gap_left = 0;
  int         rep_tbl [N_REQ] = '{3, 1, 2, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int top_of(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_pend = '0; m_id = 0; m_rep = 0; m_age = 0; m_gap_left = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic m, input logic d);
    logic [3:0] nxt;
    int t;
    if (m) begin
      m_ph = P_IDLE;
      m_pend = '0;
      return;
    end
    nxt = m_pend | r;
    t = top_of(m_pend);
    case (m_ph)
      P_IDLE, P_STOP: begin
        if (t >= 0) begin
          m_id = t; m_rep = rep_tbl[t]; nxt[t] = r[t];
          m_ph = P_LOAD;
        end else m_ph = P_IDLE;
      end
      P_LOAD:  m_ph = P_START;
      P_START: begin m_ph = P_PLAY; m_age = 0; end
      P_PLAY: begin
        m_age++;
        if (d) begin m_ph = P_GAP; m_gap_left = GAP_N; end
        else if (t > m_id) m_ph = P_STOP;
        else if (m_age == TMO_N) begin m_ph = P_GAP; m_gap_left = GAP_N; end
      end
      P_GAP: begin
        m_gap_left--;
        if (m_gap_left == 0) m_ph = P_IDLE;
      end
      default: m_ph = P_IDLE;
    endcase
    m_pend = nxt;
  endtask

  task automatic compare_all();
    chk("snd_id",    32'(snd_id_o),    32'(m_id));
    chk("snd_rep",   32'(snd_rep_o),   32'(m_rep));
    chk("snd_start", 32'(snd_start_o), 32'(m_ph == P_START));
    chk("onOff",     32'(onOff_o),     32'(m_ph == P_START || m_ph == P_PLAY));
    chk("busy",      32'(busy_o),      32'(m_ph != P_IDLE));
    chk("pending",   32'(pending_o),   32'(m_pend));
  endtask

  task automatic step(input logic [3:0] r, input logic m, input logic d);
    @(negedge MCLK);
    req = r; mute = m; done = d;
    @(posedge MCLK);
    model_step(r, m, d);
    #1;
    compare_all();
  endtask

  task automatic run_until(input phase_t p, input string tag);
    int n = 0;
    while (m_ph != p && n < 2000) begin
      step(4'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_ph != p) chk({tag, "_bound"}, 32'(n), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_id"},    32'(snd_id_o),    32'(0));
    chk({tag, "_rep"},   32'(snd_rep_o),   32'(0));
    chk({tag, "_start"}, 32'(snd_start_o), 32'(0));
    chk({tag, "_onoff"}, 32'(onOff_o),     32'(0));
    chk({tag, "_busy"},  32'(busy_o),      32'(0));
    chk({tag, "_pend"},  32'(pending_o),   32'(0));
  endtask

  initial begin
    int n;
    logic [3:0] r;
    logic m, d;

    // Power-on reset
    #12;
    chk_all_zero("por");
    @(negedge MCLK); nReset = 1'b1;

    // Single low-priority effect: latency, values, gap length
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("lat_start", 32'(snd_start_o), 32'(1));
    chk("a_id",      32'(snd_id_o),    32'(0));
    chk("a_rep",     32'(snd_rep_o),   32'(3));
    chk("a_onoff",   32'(onOff_o),     32'(1));
    run_until(P_PLAY, "a_play");
    step(4'b0000, 1'b0, 1'b1);
    chk("a_gap_onoff", 32'(onOff_o), 32'(0));
    n = 0;
    while (busy_o && n < GAP_N + 10) begin
      step(4'b0000, 1'b0, 1'b0);
      n++;
    end
    chk("a_gap_len", 32'(n), 32'(GAP_N));

    // Two simultaneous requests: higher index first, lower stays latched
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("b_id",   32'(snd_id_o),  32'(2));
    chk("b_rep",  32'(snd_rep_o), 32'(2));
    chk("b_pend", 32'(pending_o), 32'(4'b0001));
    run_until(P_PLAY, "b_play");
    step(4'b0000, 1'b0, 1'b1);
    run_until(P_START, "b_next");
    chk("b_next_id", 32'(snd_id_o), 32'(0));
    run_until(P_PLAY, "b_play2");
    step(4'b0000, 1'b0, 1'b1);
    run_until(P_IDLE, "b_idle");

    // Preemption of effect 1 by effect 3
    step(4'b0010, 1'b0, 1'b0);
    run_until(P_PLAY, "c_play");
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("c_stop_onoff", 32'(onOff_o), 32'(0));
    step(4'b0000, 1'b0, 1'b0);
    chk("c_id",   32'(snd_id_o),  32'(3));
    chk("c_rep",  32'(snd_rep_o), 32'(4));
    chk("c_pend", 32'(pending_o), 32'(0));
    step(4'b0000, 1'b0, 1'b0);
    chk("c_start", 32'(snd_start_o), 32'(1));
    run_until(P_PLAY, "c_play2");
    step(4'b0000, 1'b0, 1'b1);
    run_until(P_IDLE, "c_idle");

    // Completion and preempting request in the same cycle
    step(4'b0100, 1'b0, 1'b0);
    run_until(P_PLAY, "d_play");
    step(4'b1000, 1'b0, 1'b1);
    chk("d_onoff", 32'(onOff_o),   32'(0));
    chk("d_pend",  32'(pending_o), 32'(4'b1000));
    chk("d_busy",  32'(busy_o),    32'(1));
    run_until(P_START, "d_next");
    chk("d_next_id", 32'(snd_id_o), 32'(3));
    run_until(P_PLAY, "d_play2");
    step(4'b0000, 1'b0, 1'b1);
    run_until(P_IDLE, "d_idle");

    // Timeout with play_done withheld
    step(4'b0001, 1'b0, 1'b0);
    run_until(P_PLAY, "e_play");
    n = 0;
    while (onOff_o && n < TMO_N + 10) begin
      step(4'b0000, 1'b0, 1'b0);
      n++;
    end
    chk("e_tmo_len", 32'(n), 32'(TMO_N));
    run_until(P_IDLE, "e_idle");

    // Mute flushes pending and blocks new requests
    step(4'b1000, 1'b0, 1'b0);
    run_until(P_PLAY, "f_play");
    step(4'b0110, 1'b0, 1'b0);
    chk("f_pend", 32'(pending_o), 32'(4'b0110));
    step(4'b0000, 1'b1, 1'b0);
    chk("f_mute_pend",  32'(pending_o), 32'(0));
    chk("f_mute_onoff", 32'(onOff_o),   32'(0));
    chk("f_mute_id",    32'(snd_id_o),  32'(3));
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("f_mute_ign", 32'(pending_o), 32'(0));
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("f_unmute_busy", 32'(busy_o), 32'(0));

    // Asynchronous reset mid-play
    step(4'b0100, 1'b0, 1'b0);
    run_until(P_PLAY, "g_play");
    repeat (5) step(4'b0000, 1'b0, 1'b0);
    @(negedge MCLK);
    #2 nReset = 1'b0;
    #1;
    chk_all_zero("g_rst");
    m_reset();
    repeat (2) @(posedge MCLK);
    @(negedge MCLK); nReset = 1'b1;
    step(4'b0000, 1'b0, 1'b0);

    // Random traffic
    for (int c = 0; c < 6000; c++) begin
      r = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
      m = ($urandom_range(0, 399) == 0);
      d = ($urandom_range(0, 24) == 0);
      step(r, m, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
Sequences sound effects onto the single shared I2S audio path (tone store + transmitter). Arbitrates pulse requests from game logic (shot, invader step, explosion, UFO) by fixed priority, latches pending requests, and drives tone select, repeat count, start strobe and onOff to the player. Supports preemption by higher-priority effects, an inter-effect silence gap and a global mute.

Parameters:
N_REQ, 4, number of requesters; index N_REQ-1 is highest priority
ID_W, 2, width of tone select (clog2 of N_REQ)
REP_W, 8, width of repeat count per effect
REP_TABLE, {8'd4,8'd2,8'd1,8'd3}, packed repeat counts, slice i = requester i
GAP_CYCLES, 16'd1000, MCLK cycles of forced silence between effects
TIMEOUT, 24'd5000000, MCLK cycles after which a playing effect is aborted

Ports:
MCLK  in  1  system clock (25 MHz)
nReset  in  1  asynchronous active-low reset
req  in  N_REQ  one-cycle request pulses, bit i = effect i
mute  in  1  level; forces silence and flushes pending
play_done  in  1  one-cycle pulse from player: repeat count exhausted
snd_id  out  ID_W  tone select to tone store
snd_rep  out  REP_W  repeat count for current effect
snd_start  out  1  one-cycle strobe: player resets address/repeat counters
onOff  out  1  enable to I2S transmitter
busy  out  1  high in any state other than IDLE
pending  out  N_REQ  latched, not-yet-served requests

Behaviour:
- Reset (async): state IDLE, snd_id 0, snd_rep 0, snd_start 0, onOff 0, busy 0, pending 0, gap/timeout counters 0.
- pending[i] set on req[i]; cleared when effect i is selected. Set and clear in same cycle: set wins (bit stays 1).
- Selection: highest set index of pending. Combinational pick, registered into snd_id/snd_rep.
- States: IDLE, LOAD, START, PLAY, STOP, GAP.
- IDLE: pending != 0 and mute=0 -> latch snd_id=pick, snd_rep=REP_TABLE[pick], clear pending[pick] -> LOAD.
- LOAD: one cycle for tone store to present data -> START.
- START: snd_start=1 for exactly one cycle, onOff=1 from this cycle -> PLAY. Latency req pulse to snd_start from IDLE = 3 cycles.
- PLAY: onOff=1; timeout counter increments each cycle.
  - play_done -> GAP.
  - any pending bit with index > snd_id -> STOP (preempt); preempted effect is dropped, not re-queued.
  - timeout counter reaches TIMEOUT-1 -> GAP (abort).
  - play_done and preempting request same cycle: play_done wins (-> GAP); new request stays pending.
  - re-request of current snd_id while in PLAY: latched in pending, served after GAP.
- STOP: onOff=0 for one cycle -> select pick immediately (as IDLE) -> LOAD. No gap on preemption.
- GAP: onOff=0; counts GAP_CYCLES cycles then -> IDLE. Requests still latched during GAP.
- mute=1 in any state: next cycle state IDLE, onOff 0, pending cleared, req ignored while mute=1. snd_id/snd_rep hold last value.
- snd_start never asserted twice without intervening state change; onOff is low in IDLE, STOP, GAP.
- Counters saturate-free: cleared on entry to their state.

Test Plan:
- Reset mid-PLAY (nReset low 2 cycles) -> all outputs 0 immediately (async), state IDLE, pending 0.
- req=4'b0001 single pulse from IDLE -> 3 cycles later snd_start=1 one cycle, snd_id=0, snd_rep=3, onOff=1; play_done -> onOff 0 for 1000 cycles, then busy=0.
- req=4'b0101 same cycle -> effect 2 plays first (snd_rep=2), pending=4'b0001; after play_done+gap effect 0 starts.
- effect 1 playing, req[3] pulse -> one cycle onOff=0, then snd_id=3, snd_rep=4, snd_start pulse; effect 1 not in pending.
- effect 2 playing, req[3] and play_done same cycle -> GAP entered, pending=4'b1000, effect 3 starts after 1000-cycle gap.
- play_done withheld -> onOff drops exactly TIMEOUT cycles after PLAY entry; mute=1 with pending=4'b0110 -> pending 0, onOff 0 next cycle, req pulses ignored until mute=0.
